// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-FFT sample loading path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_CSUM,
    ST_WAIT
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam int unsigned DEF_N_SAMPLES      = 64;
  localparam int unsigned DEF_ADDR_WIDTH     = 6;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_TIMER_WIDTH    = $clog2(DEF_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// saturates at LIMIT so a stalled frame cannot wrap back to a non-expired value.
module frame_timer #(
  parameter int unsigned LIMIT = uart_pkg::DEF_TIMEOUT_CYCLES,
  parameter int unsigned WIDTH = uart_pkg::DEF_TIMER_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_V)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = enable && (count == LIMIT_V);

endmodule

// File: rtl/uart_sample_loader.sv
// Parses SYNC/{lo,hi}xN/checksum frames from uart_rx into the FFT sample RAM
// and releases a single FFT start pulse for each good frame.
module uart_sample_loader
  import uart_pkg::*;
#(
  parameter int unsigned N_SAMPLES      = DEF_N_SAMPLES,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_flag,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_fft_busy,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [15:0]           o_wr_data,
  output logic                  o_fft_start,
  output logic                  o_frame_done,
  output logic                  o_frame_err
);

  localparam int unsigned        TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_SAMPLES - 1);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   idx, idx_nx;
  logic [7:0]              csum, csum_nx;
  logic [7:0]              lo, lo_nx;

  logic                    wr_en_nx;
  logic [ADDR_WIDTH-1:0]   wr_addr_nx;
  logic [15:0]             wr_data_nx;
  logic                    start_nx;
  logic                    done_nx;
  logic                    err_nx;

  logic                    in_frame;
  logic                    timer_clear;
  logic                    expired;

  assign in_frame    = (state == ST_LO) || (state == ST_HI) || (state == ST_CSUM);
  assign timer_clear = i_rx_flag || !in_frame;

  frame_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (timer_clear),
    .enable  (in_frame),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      csum         <= '0;
      lo           <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_fft_start  <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      csum         <= csum_nx;
      lo           <= lo_nx;
      o_wr_en      <= wr_en_nx;
      o_wr_addr    <= wr_addr_nx;
      o_wr_data    <= wr_data_nx;
      o_fft_start  <= start_nx;
      o_frame_done <= done_nx;
      o_frame_err  <= err_nx;
    end
  end

  // A matching checksum with the core already idle skips WAIT so the start
  // pulse lands one cycle after the checksum byte rather than two.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    csum_nx    = csum;
    lo_nx      = lo;
    wr_en_nx   = 1'b0;
    wr_addr_nx = o_wr_addr;
    wr_data_nx = o_wr_data;
    start_nx   = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_rx_flag && (i_rx_byte == SYNC_BYTE) && !i_fft_busy) begin
          state_nx = ST_LO;
          idx_nx   = '0;
          csum_nx  = '0;
        end
      end

      ST_LO: begin
        if (i_rx_flag) begin
          lo_nx    = i_rx_byte;
          csum_nx  = csum ^ i_rx_byte;
          state_nx = ST_HI;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_HI: begin
        if (i_rx_flag) begin
          csum_nx    = csum ^ i_rx_byte;
          wr_en_nx   = 1'b1;
          wr_addr_nx = idx;
          wr_data_nx = {i_rx_byte, lo};
          if (idx == LAST_IDX) begin
            state_nx = ST_CSUM;
          end else begin
            idx_nx   = idx + ADDR_WIDTH'(1);
            state_nx = ST_LO;
          end
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_CSUM: begin
        if (i_rx_flag) begin
          if (i_rx_byte != csum) begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
          end else if (i_fft_busy) begin
            state_nx = ST_WAIT;
          end else begin
            start_nx = 1'b1;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (!i_fft_busy) begin
          start_nx = 1'b1;
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_sample_loader.sv
// Self-checking bench for uart_sample_loader: scenario table plus hand-written
// timeout, byte-vs-timeout and mid-frame reset sequences.
module tb_uart_sample_loader;

  localparam int         N    = 64;
  localparam int         TMO  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_flag;
  logic [7:0]  rx_byte;
  logic        fft_busy;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        fft_start;
  logic        frame_done;
  logic        frame_err;

  uart_sample_loader #(
    .N_SAMPLES      (N),
    .ADDR_WIDTH     (6),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_flag    (rx_flag),
    .i_rx_byte    (rx_byte),
    .i_fft_busy   (fft_busy),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_fft_start  (fft_start),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output capture
  logic [5:0]  got_addr[$];
  logic [15:0] got_data[$];
  int   n_err, n_start, n_done, err_cyc, start_cyc;
  logic prev_start = 1'b0;
  logic prev_err   = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      check("wr_while_busy", {31'd0, fft_busy}, 0);
    end
    if (fft_start) begin
      n_start++;
      start_cyc = cyc;
      check("done_with_start", {31'd0, frame_done}, 1);
      check("start_width", {31'd0, prev_start}, 0);
    end
    if (frame_done) n_done++;
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
      check("err_width", {31'd0, prev_err}, 0);
    end
    prev_start = fft_start;
    prev_err   = frame_err;
  end

  task automatic clear_capture();
    got_addr.delete();
    got_data.delete();
    n_err = 0; n_start = 0; n_done = 0;
    err_cyc = -1; start_cyc = -1;
  endtask

  // Reference data: sample values and the checksum the spec defines over them
  logic [15:0] smp [N];
  int last_flag_cyc;

  function automatic logic [7:0] ref_csum(input int count);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < count; k++) c = c ^ smp[k][7:0] ^ smp[k][15:8];
    return c;
  endfunction

  task automatic fill(input int pattern);
    for (int k = 0; k < N; k++)
      smp[k] = (pattern == 0) ? 16'(16'h0100 + k) : 16'($urandom);
    if (pattern == 2) begin
      smp[3][7:0]   = SYNC;
      smp[10][15:8] = SYNC;
      smp[20]       = {SYNC, SYNC};
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    @(posedge clk); #1;
    rx_flag = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_flag = 1'b0;
    rx_byte = 8'($urandom);
    last_flag_cyc = cyc;
    g = $urandom_range(0, 2);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic check_writes(input string tag, input int exp_n);
    check({tag, "_nwr"}, got_addr.size(), exp_n);
    for (int k = 0; k < exp_n && k < got_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), {26'd0, got_addr[k]}, k);
      check($sformatf("%s_data%0d", tag, k), {16'd0, got_data[k]}, {16'd0, smp[k]});
    end
  endtask

  typedef struct {
    string      name;
    int         pattern;
    logic [7:0] cx;
    int         noise;
    bit         busy_sync;
    bit         busy_wait;
    int         exp_wr;
    int         exp_start;
    int         exp_err;
  } scen_t;

  scen_t tbl[7];

  task automatic run_scen(input scen_t s);
    logic [7:0] ck;
    int csum_cyc, fall_cyc;
    fill(s.pattern);
    ck = ref_csum(N) ^ s.cx;
    clear_capture();
    fall_cyc = -1;
    if (s.busy_sync) fft_busy = 1'b1;
    for (int i = 0; i < s.noise; i++) send_byte((i % 2 == 0) ? 8'h00 : 8'hFF);
    send_byte(SYNC);
    for (int k = 0; k < N; k++) begin
      send_byte(smp[k][7:0]);
      send_byte(smp[k][15:8]);
    end
    if (s.busy_wait) begin
      @(posedge clk); #1;
      fft_busy = 1'b1;
    end
    send_byte(ck);
    csum_cyc = last_flag_cyc;
    if (s.busy_wait) begin
      send_byte(SYNC);
      send_byte(8'h12);
      send_byte(8'h34);
      while (cyc < csum_cyc + 20) begin @(posedge clk); #1; end
      check({s.name, "_no_early_start"}, n_start, 0);
      fft_busy = 1'b0;
      fall_cyc = cyc;
    end
    repeat (6) begin @(posedge clk); #1; end
    fft_busy = 1'b0;
    check_writes(s.name, s.exp_wr);
    check({s.name, "_nstart"}, n_start, s.exp_start);
    check({s.name, "_ndone"}, n_done, s.exp_start);
    check({s.name, "_nerr"}, n_err, s.exp_err);
    if (s.exp_start != 0)
      check({s.name, "_start_cyc"}, start_cyc, s.busy_wait ? fall_cyc + 1 : csum_cyc);
    if (s.exp_err != 0)
      check({s.name, "_err_cyc"}, err_cyc, csum_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    tbl[0] = '{"good_ramp",    0, 8'h00, 0, 1'b0, 1'b0, 64, 1, 0};
    tbl[1] = '{"bad_csum",     0, 8'h01, 0, 1'b0, 1'b0, 64, 0, 1};
    tbl[2] = '{"busy_wait",    1, 8'h00, 0, 1'b0, 1'b1, 64, 1, 0};
    tbl[3] = '{"noise_sync",   2, 8'h00, 2, 1'b0, 1'b0, 64, 1, 0};
    tbl[4] = '{"bad_csum_msb", 1, 8'h80, 0, 1'b0, 1'b0, 64, 0, 1};
    tbl[5] = '{"busy_at_sync", 1, 8'h00, 0, 1'b1, 1'b0,  0, 0, 0};
    tbl[6] = '{"random_good",  1, 8'h00, 1, 1'b0, 1'b0, 64, 1, 0};

    rst = 1'b1; rx_flag = 1'b0; rx_byte = 8'h00; fft_busy = 1'b0;
    clear_capture();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_addr", {26'd0, wr_addr}, 0);
    check("rst_wr_data", {16'd0, wr_data}, 0);
    check("rst_pulses", {29'd0, fft_start, frame_done, frame_err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_scen(tbl[i]);

    // Timeout after 10 payload bytes, then a clean frame
    fill(1);
    clear_capture();
    send_byte(SYNC);
    for (int k = 0; k < 5; k++) begin
      send_byte(smp[k][7:0]);
      send_byte(smp[k][15:8]);
    end
    lc = last_flag_cyc;
    for (int i = 0; i < TMO + 20 && n_err == 0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    check("tmo_nerr", n_err, 1);
    check("tmo_err_not_early", {31'd0, err_cyc >= lc + TMO}, 1);
    check("tmo_err_not_late", {31'd0, err_cyc <= lc + TMO + 2}, 1);
    check("tmo_nstart", n_start, 0);
    check_writes("tmo", 5);
    run_scen(tbl[0]);

    // Byte arriving on the timeout boundary keeps the frame alive
    fill(1);
    clear_capture();
    send_byte(SYNC);
    lc = last_flag_cyc;
    while (cyc < lc + TMO) begin @(posedge clk); #1; end
    rx_flag = 1'b1;
    rx_byte = smp[0][7:0];
    @(posedge clk); #1;
    rx_flag = 1'b0;
    send_byte(smp[0][15:8]);
    for (int k = 1; k < N; k++) begin
      send_byte(smp[k][7:0]);
      send_byte(smp[k][15:8]);
    end
    send_byte(ref_csum(N));
    repeat (4) begin @(posedge clk); #1; end
    check("edge_nerr", n_err, 0);
    check("edge_nstart", n_start, 1);
    check_writes("edge", 64);

    // Reset after 30 samples: silent abort, fresh frame restarts at addr 0
    fill(1);
    clear_capture();
    send_byte(SYNC);
    for (int k = 0; k < 30; k++) begin
      send_byte(smp[k][7:0]);
      send_byte(smp[k][15:8]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_wr_en", {31'd0, wr_en}, 0);
    check("mrst_wr_addr", {26'd0, wr_addr}, 0);
    check("mrst_wr_data", {16'd0, wr_data}, 0);
    check("mrst_pulses", {29'd0, fft_start, frame_done, frame_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (TMO + 10) begin @(posedge clk); #1; end
    check("mrst_nerr", n_err, 0);
    check("mrst_nstart", n_start, 0);
    check_writes("mrst", 30);
    run_scen(tbl[6]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
